uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
//  Packet-level round-robin scheduler sharing the single UART transmitter among NUM_REQ byte-stream requesters
//  (telemetry, debug, command ack). Sits between the requesters and the UART TX core: it drives tx_data_o/tx_en_o
//  and tracks tx_busy_i. Once granted, a requester owns the UART until its last byte has gone out, so packets
//  never interleave.
// PARAMETERS
//  NUM_REQ     3     number of requesters (2..8)
//  STALL_MAX   4096  cycles a granted requester may hold req_valid low mid-packet before the packet is aborted
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          asynchronous reset, active-low
//  req_valid_i    in   NUM_REQ    requester i presents a byte
//  req_data_i     in   8*NUM_REQ  byte of requester i, in bits [8i+7:8i]
//  req_last_i     in   NUM_REQ    byte of requester i is the final byte of its packet
//  req_ready_o    out  NUM_REQ    one-cycle accept pulse to requester i
//  tx_data_o      out  8          byte to the UART TX core
//  tx_en_o        out  1          one-cycle start pulse to the UART TX core
//  tx_busy_i      in   1          UART TX core busy
//  grant_o        out  NUM_REQ    one-hot owner of the UART; 0 when idle
//  active_o       out  1          a packet is in progress
//  abort_o        out  1          one-cycle pulse when a packet is aborted on stall timeout
// BEHAVIOUR
//  Reset: all outputs 0 (tx_data_o=8'h00), round-robin pointer=0, state IDLE. Reset mid-byte drops tx_en_o at once;
//   the UART core shares rst_n.
//  States:
//   - IDLE: if any req_valid_i is set, grant the first set bit at or after the pointer (cyclic) -> grant_o, active_o=1,
//     then go to LOAD. Otherwise stay.
//   - LOAD: if req_valid_i[g]=1, pulse req_ready_o[g], latch data into tx_data_o and last into last_q, then go to START.
//     If req_valid_i[g]=0, increment the stall counter; at STALL_MAX-1, pulse abort_o and go to RELEASE.
//     The stall counter clears on every accepted byte.
//   - START: tx_en_o=1 for exactly one cycle, then go to WAIT_HI. tx_en_o is never asserted while tx_busy_i=1.
//   - WAIT_HI: wait for tx_busy_i=1. The UART core raises busy the cycle after en, so this normally lasts 1 cycle.
//   - WAIT_LO: wait for tx_busy_i=0 (stop bit done). Then, if last_q=1, go to CSUM (if enabled) or RELEASE;
//     otherwise go to LOAD.
//   - RELEASE: pointer <= index(g)+1, wrapping to 0 after NUM_REQ-1. grant_o=0, active_o=0, then go to IDLE.
//  Latency: valid to tx_en_o is 2 cycles from LOAD. Back-to-back byte gap is 3 clk beyond the UART frame.
//  Simultaneous requests: resolved only in IDLE by the rotating pointer. A request arriving mid-packet waits.
//   A requester that deasserts valid in IDLE is not granted.
//  req_data_i/req_last_i of non-granted requesters are ignored. req_ready_o is one-hot or zero.
//  tx_data_o holds its value from LOAD through WAIT_LO.
// CONFIGURATION
//  UART_TX_SCHED_CSUM_EN defined:
//   - a running XOR of all accepted packet bytes (cleared in IDLE) is sent as an extra byte after the last byte;
//   - CSUM reuses the START/WAIT_HI/WAIT_LO sequence and then goes to RELEASE;
//   - an aborted packet sends no checksum.
//  Undefined: no checksum byte and no XOR register. The packet ends after the last requester byte.
// STRUCTURE
//  Shared package uart_pkg:
//   - state encoding typedef (IDLE, LOAD, START, WAIT_HI, WAIT_LO, CSUM, RELEASE);
//   - UART_BYTE_W=8;
//   - default STALL_MAX.
//  Sub-module rr_arbiter: inputs req vector and pointer; outputs one-hot grant and grant index. Purely combinational.
//  Kept separate for reuse by the RX-side dispatcher.
// TESTING
//  Bench uses a behavioural UART core: busy rises 1 clk after en and lasts 10 clk per byte.
//  1. Req0 sends {8'hA5,8'h5A(last)}; others idle -> two tx_en_o pulses with data A5 then 5A. grant_o=3'b001 throughout,
//     then 0. With CSUM_EN, a third byte FF.
//  2. Req0..2 all valid, single-byte packets, pointer=0 -> service order 0,1,2. A second round, with all still valid,
//     is again 0,1,2.
//  3. Req1 mid-packet while req2 raises valid -> req2 is not granted until req1's last byte finishes.
//     No interleaved bytes on tx_data_o.
//  4. Req0 sends 1 byte, then drops valid for STALL_MAX cycles -> abort_o pulses once, grant_o=0, and the next
//     requester is served. With CSUM_EN, no checksum byte.
//  5. rst_n asserted during WAIT_LO -> all outputs 0 immediately. After release, a fresh req2 packet is served with
//     pointer=0.
//  6. Hold tx_busy_i=1 externally in IDLE with req0 valid -> tx_en_o waits in WAIT_LO/START ordering. No en while busy.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width, the default stall limit,
// the FSM state encoding and the checksum fold helper.
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int STALL_MAX_DEF = 4096;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_START   = 3'd2;
    localparam state_t S_WAIT_HI = 3'd3;
    localparam state_t S_WAIT_LO = 3'd4;
    localparam state_t S_CSUM    = 3'd5;
    localparam state_t S_RELEASE = 3'd6;

    function automatic logic [UART_BYTE_W-1:0] csum_fold(input logic [UART_BYTE_W-1:0] acc,
                                                         input logic [UART_BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr_i, cyclically.
// Shared with the RX-side dispatcher.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;
    logic          hit_s;
    logic          found_s;

    // scan N candidates starting at the pointer; the first hit wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s   = {1'b0, ptr_i} + (IW+1)'(k);
            cand_s  = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : sum_s[IW-1:0];
            hit_s   = !found_s && req_i[cand_s];
            grant_o[cand_s] = grant_o[cand_s] | hit_s;
            idx_o   = hit_s ? cand_s : idx_o;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler in front of a single UART TX core; a granted requester keeps
// the UART until its last byte is sent. Define UART_TX_SCHED_CSUM_EN to append an XOR checksum byte.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [UART_BYTE_W-1:0]         tx_data_o,
    output logic                           tx_en_o,
    input  logic                           tx_busy_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           active_o,
    output logic                           abort_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(STALL_MAX);

    state_t                   state_q, state_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [IW-1:0]            gidx_q, gidx_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic                     active_q, active_d;
    logic [UART_BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                     tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0]       ready_q, ready_d;
    logic                     abort_q, abort_d;
    logic                     last_q, last_d;
    logic [SW-1:0]            stall_q, stall_d;
    logic [NUM_REQ-1:0]       arb_grant_s;
    logic [IW-1:0]            arb_idx_s;
`ifdef UART_TX_SCHED_CSUM_EN
    logic [UART_BYTE_W-1:0]   csum_q, csum_d;
    logic                     csum_sent_q, csum_sent_d;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s)
    );

    // next-state and output decode; pulses default low every cycle
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        active_d  = active_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        ready_d   = '0;
        abort_d   = 1'b0;
        last_d    = last_q;
        stall_d   = stall_q;
`ifdef UART_TX_SCHED_CSUM_EN
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
`endif
        case (state_q)
            S_IDLE: begin
                stall_d = '0;
`ifdef UART_TX_SCHED_CSUM_EN
                csum_d      = '0;
                csum_sent_d = 1'b0;
`endif
                if (|req_valid_i) begin
                    grant_d  = arb_grant_s;
                    gidx_d   = arb_idx_s;
                    active_d = 1'b1;
                    state_d  = S_LOAD;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_LOAD: begin
                if (req_valid_i[gidx_q]) begin
                    ready_d[gidx_q] = 1'b1;
                    tx_data_d = req_data_i[{gidx_q, 3'b000} +: UART_BYTE_W];
                    last_d    = req_last_i[gidx_q];
                    stall_d   = '0;
`ifdef UART_TX_SCHED_CSUM_EN
                    csum_d    = csum_fold(csum_q, req_data_i[{gidx_q, 3'b000} +: UART_BYTE_W]);
`endif
                    state_d   = S_START;
                end else if (stall_q == SW'(STALL_MAX - 1)) begin
                    abort_d = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            S_START: begin
                // hold off the start pulse while the core still reports busy
                if (!tx_busy_i) begin
                    tx_en_d = 1'b1;
                    state_d = S_WAIT_HI;
                end else begin
                    state_d = S_START;
                end
            end
            S_WAIT_HI: begin
                state_d = tx_busy_i ? S_WAIT_LO : S_WAIT_HI;
            end
            S_WAIT_LO: begin
                if (tx_busy_i) begin
                    state_d = S_WAIT_LO;
                end else if (last_q) begin
`ifdef UART_TX_SCHED_CSUM_EN
                    state_d = csum_sent_q ? S_RELEASE : S_CSUM;
`else
                    state_d = S_RELEASE;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef UART_TX_SCHED_CSUM_EN
            S_CSUM: begin
                tx_data_d   = csum_q;
                csum_sent_d = 1'b1;
                state_d     = S_START;
            end
`endif
            S_RELEASE: begin
                ptr_d    = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
                grant_d  = '0;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                grant_d  = '0;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            active_q  <= 1'b0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            ready_q   <= '0;
            abort_q   <= 1'b0;
            last_q    <= 1'b0;
            stall_q   <= '0;
`ifdef UART_TX_SCHED_CSUM_EN
            csum_q      <= 8'h00;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            active_q  <= active_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            ready_q   <= ready_d;
            abort_q   <= abort_d;
            last_q    <= last_d;
            stall_q   <= stall_d;
`ifdef UART_TX_SCHED_CSUM_EN
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    assign req_ready_o = ready_q;
    assign tx_data_o   = tx_data_q;
    assign tx_en_o     = tx_en_q;
    assign grant_o     = grant_q;
    assign active_o    = active_q;
    assign abort_o     = abort_q;

endmodule
